// File: rtl/rfid_frame_rx.sv
// rfid_frame_rx: 16x-oversampled 8N1 receiver feeding a header-hunting frame collector
// with XOR checksum, framing-error and inter-byte timeout reporting.
module rfid_frame_rx #(
   parameter int unsigned CLK_HZ       = 24000000,
   parameter int unsigned BAUD         = 9600,
   parameter int unsigned FRAME_LEN    = 10,
   parameter logic [7:0]  HEADER       = 8'hBB,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic                       clk_24M,
   input  logic                       rst,
   input  logic                       rxd,
   output logic [8*(FRAME_LEN-2)-1:0] card_id,
   output logic                       frame_valid,
   output logic                       frame_err,
   output logic [1:0]                 err_code,
   output logic                       busy
);

   localparam int unsigned DIV      = CLK_HZ / (BAUD * 16);
   localparam int unsigned DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned PW       = 8 * (FRAME_LEN - 2);
   localparam int unsigned IDX_W    = 4;
   localparam int unsigned TO_TICKS = TIMEOUT_BITS * 16;
   localparam int unsigned GAP_W    = $clog2(TO_TICKS + 1);

   typedef enum logic [2:0] {U_IDLE, U_START, U_DATA, U_STOP, U_WAIT_HIGH} uart_state_e;
   typedef enum logic {F_HUNT, F_COLLECT} frame_state_e;

   logic              rxd_meta_q, line_q;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              tick;
   logic              maj;

   uart_state_e       uart_q, uart_d;
   logic [3:0]        samp_q, samp_d;
   logic [3:0]        bit_q, bit_d;
   logic [7:0]        shreg_q, shreg_d;
   logic [1:0]        hist_q, hist_d;
   logic              byte_done_q, byte_done_d;
   logic              byte_err_q, byte_err_d;

   frame_state_e      fr_q, fr_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [7:0]        cks_q, cks_d;
   logic [PW-1:0]     pay_q, pay_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [PW-1:0]     card_q, card_d;
   logic              fv_q, fv_d;
   logic              fe_q, fe_d;
   logic [1:0]        ec_q, ec_d;
   logic              busy_q, busy_d;

   assign tick = (div_q == DIV_W'(DIV - 1));
   assign div_d = tick ? '0 : div_q + DIV_W'(1);
   // Vote over the two previous samples and the current one.
   assign maj = (hist_q[1] & hist_q[0]) | (hist_q[1] & line_q) | (hist_q[0] & line_q);

   // UART byte receiver
   always_comb begin
      uart_d      = uart_q;
      samp_d      = samp_q;
      bit_d       = bit_q;
      shreg_d     = shreg_q;
      hist_d      = hist_q;
      byte_done_d = 1'b0;
      byte_err_d  = 1'b0;
      if (tick) begin
         hist_d = {hist_q[0], line_q};
         samp_d = samp_q + 4'd1;
         unique case (uart_q)
            U_IDLE: begin
               if (!line_q) begin
                  uart_d = U_START;
                  samp_d = 4'd1;  // the detecting tick is sample 0
                  bit_d  = 4'd0;
               end
            end
            U_START: begin
               if (samp_q == 4'd8) begin
                  uart_d = line_q ? U_IDLE : U_DATA;
                  bit_d  = 4'd0;
               end
            end
            U_DATA: begin
               // The first sample-9 tick after entry still lies in the start bit.
               if (samp_q == 4'd9) begin
                  bit_d = bit_q + 4'd1;
                  if (bit_q != 4'd0) shreg_d = {maj, shreg_q[7:1]};
                  if (bit_q == 4'd8) uart_d = U_STOP;
               end
            end
            U_STOP: begin
               if (samp_q == 4'd8) begin
                  if (maj) begin
                     uart_d      = U_IDLE;
                     byte_done_d = 1'b1;
                  end else begin
                     uart_d     = U_WAIT_HIGH;
                     byte_err_d = 1'b1;
                  end
               end
            end
            U_WAIT_HIGH: begin
               if (line_q) uart_d = U_IDLE;
            end
            default: uart_d = U_IDLE;
         endcase
      end
   end

   // Frame assembly, checksum and error reporting
   always_comb begin
      fr_d   = fr_q;
      idx_d  = idx_q;
      cks_d  = cks_q;
      pay_d  = pay_q;
      gap_d  = gap_q;
      card_d = card_q;
      fv_d   = 1'b0;
      fe_d   = 1'b0;
      ec_d   = ec_q;
      busy_d = (uart_q != U_IDLE) || (fr_q != F_HUNT);
      unique case (fr_q)
         F_HUNT: begin
            gap_d = '0;
            if (byte_done_q && shreg_q == HEADER) begin
               fr_d  = F_COLLECT;
               idx_d = IDX_W'(1);
               cks_d = 8'h00;
            end
         end
         F_COLLECT: begin
            if (byte_done_q) begin
               gap_d = '0;
               if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
                  fr_d = F_HUNT;
                  if (shreg_q == cks_q) begin
                     card_d = pay_q;
                     fv_d   = 1'b1;
                  end else begin
                     fe_d = 1'b1;
                     ec_d = 2'b10;
                  end
               end else begin
                  // Payload shifts in so byte 1 ends up in the MSBs.
                  pay_d = PW'({pay_q, shreg_q});
                  cks_d = cks_q ^ shreg_q;
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (byte_err_q) begin
               fr_d = F_HUNT;
               fe_d = 1'b1;
               ec_d = 2'b01;
            end else if (tick && uart_q == U_IDLE) begin
               if (gap_q == GAP_W'(TO_TICKS - 1)) begin
                  fr_d = F_HUNT;
                  fe_d = 1'b1;
                  ec_d = 2'b11;
               end else begin
                  gap_d = gap_q + GAP_W'(1);
               end
            end
         end
         default: fr_d = F_HUNT;
      endcase
   end

   always_ff @(posedge clk_24M or negedge rst) begin
      if (!rst) begin
         rxd_meta_q  <= 1'b1;
         line_q      <= 1'b1;
         div_q       <= '0;
         uart_q      <= U_IDLE;
         samp_q      <= 4'd0;
         bit_q       <= 4'd0;
         shreg_q     <= 8'h00;
         hist_q      <= 2'b11;
         byte_done_q <= 1'b0;
         byte_err_q  <= 1'b0;
         fr_q        <= F_HUNT;
         idx_q       <= '0;
         cks_q       <= 8'h00;
         pay_q       <= '0;
         gap_q       <= '0;
         card_q      <= '0;
         fv_q        <= 1'b0;
         fe_q        <= 1'b0;
         ec_q        <= 2'b00;
         busy_q      <= 1'b0;
      end else begin
         rxd_meta_q  <= rxd;
         line_q      <= rxd_meta_q;
         div_q       <= div_d;
         uart_q      <= uart_d;
         samp_q      <= samp_d;
         bit_q       <= bit_d;
         shreg_q     <= shreg_d;
         hist_q      <= hist_d;
         byte_done_q <= byte_done_d;
         byte_err_q  <= byte_err_d;
         fr_q        <= fr_d;
         idx_q       <= idx_d;
         cks_q       <= cks_d;
         pay_q       <= pay_d;
         gap_q       <= gap_d;
         card_q      <= card_d;
         fv_q        <= fv_d;
         fe_q        <= fe_d;
         ec_q        <= ec_d;
         busy_q      <= busy_d;
      end
   end

   assign card_id     = card_q;
   assign frame_valid = fv_q;
   assign frame_err   = fe_q;
   assign err_code    = ec_q;
   assign busy        = busy_q;

endmodule

// File: doc/rfid_frame_rx.md
# rfid_frame_rx

Serial frame receiver on the RFID link, directly downstream of the RFID bit-stream transmitter. It recovers 8N1 bytes from the `rxd` line using 16x oversampling, hunts for the frame header, and collects a fixed-length frame. It checks the XOR checksum and presents the card ID with a one-cycle valid pulse. The shopping-car control logic consumes `card_id`/`frame_valid`; errors are reported, never silently dropped.

## Interface
- CLK_HZ, 24000000, clock frequency in Hz
- BAUD, 9600, line rate; oversample divider DIV = CLK_HZ/(BAUD*16), integer-truncated (156 at defaults)
- FRAME_LEN, 10, bytes per frame: header + (FRAME_LEN-2) payload + checksum; legal range 3..16
- HEADER, 8'hBB, first byte of every frame
- TIMEOUT_BITS, 20, maximum idle gap between bytes inside a frame, in bit times
- clk_24M  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rxd  in  1  serial input, idle high, LSB first; asynchronous to clk_24M
- card_id  out  8*(FRAME_LEN-2)  payload of the last good frame; byte 1 in MSBs, byte FRAME_LEN-2 in LSBs
- frame_valid  out  1  one-cycle pulse; card_id updated in the same cycle
- frame_err  out  1  one-cycle pulse on any frame abort
- err_code  out  2  held until the next frame_err: 01 framing (bad stop), 10 checksum, 11 inter-byte timeout, 00 none since reset
- busy  out  1  high while a UART byte is in progress or the frame FSM is not in HUNT

## Operation
- Reset (rst=0, async): all outputs 0; card_id 0; all FSMs in IDLE/HUNT; counters 0.
- rxd passes through a 2-FF synchronizer, whose output is reset to 1. All logic uses the synchronized value.
- Oversample tick: free-running counter 0..DIV-1; the tick pulses for one clk at wrap.
- UART FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE→START on the first tick that sees line=0; the sample counter clears.
  - START: at sample count 8, line=1 is a glitch → IDLE. Line=0 → DATA.
  - DATA: each bit is the majority of samples 7, 8, 9 of its 16. Bits shift LSB first. After 8 bits → STOP.
  - STOP: majority at sample 8. A result of 1 raises internal byte_done and goes → IDLE. A result of 0 raises internal byte_err and goes → WAIT_HIGH.
  - WAIT_HIGH → IDLE on the first tick that sees line=1.
- Frame FSM states: HUNT, COLLECT.
  - HUNT: byte_done with data==HEADER → COLLECT, idx=1, xor=0. Other bytes are discarded silently. byte_err in HUNT gives no frame_err.
  - COLLECT, byte_done with idx<FRAME_LEN-1: store byte at payload slot idx-1, xor ^= byte, idx++.
  - COLLECT, byte_done with idx==FRAME_LEN-1 (checksum byte):
    - byte==xor → card_id loaded, frame_valid=1.
    - Otherwise frame_err=1 with err_code=10; card_id is unchanged.
    - Both cases → HUNT.
  - COLLECT, byte_err → frame_err, err_code=01, → HUNT.
  - COLLECT timeout: a gap counter counts ticks while the UART is IDLE and clears on every byte_done. Reaching TIMEOUT_BITS*16 → frame_err, err_code=11, → HUNT.
- A HEADER value inside the payload is ordinary data and does not restart the frame.

## Timing
- Synchronizer latency: 2 clk. Start detection is quantized to one tick (DIV clk).
- byte_done/byte_err are registered on the clk of the STOP sample-8 tick. frame_valid/frame_err pulse on the next clk; that is 1 clk latency from the stop-bit decision.
- frame_valid and frame_err are never high together. Each is exactly 1 clk wide. Frames can be received back-to-back with no gap.
- Timeout and byte_done on the same clk: byte_done wins, the gap counter clears, and there is no error.
- Reset mid-frame discards partial data immediately. The first frame after reset release is received normally.
- busy deasserts on the clk after frame_valid/frame_err if the UART is IDLE.

## Test plan
- Defaults; send BB 01 02 03 04 05 06 07 08 08 at 9600 baud → one frame_valid; card_id=64'h0102030405060708; frame_err never asserted.
- Same frame with checksum 09 → frame_err with err_code=10; card_id holds its previous value; a following good frame is accepted.
- Stop bit forced to 0 on payload byte 4 → frame_err with err_code=01. Line held low 3 bit times then released; the next good frame is accepted.
- Send BB 01 02, then idle 25 bit times → frame_err with err_code=11 after 20 bit times of gap; busy drops 1 clk later.
- Leading garbage 55 AA, then a 2-µs low glitch, then a good frame → garbage and glitch are ignored; exactly one frame_valid.
- Assert rst for 5 clk during byte 5 of a frame → all outputs 0. The next complete frame is received with frame_valid and the correct card_id.
